// File: rtl/freq_meter_if.sv
// freq_meter_if
//   Groups the measurement-side signals of the gated frequency meter.
//   master : the meter itself (samples sig_in/hold, drives data/valid/overflow)
//   slave  : the consumer/driver side (drives sig_in/hold, reads the result)
//   Ports
//     sig_in    signal under measurement, asynchronous to the meter clock
//     hold      1 = discard the result of the window that is ending
//     data      last latched edge count, zero-extended to 32 bits
//     valid     one-cycle pulse when data/overflow update
//     overflow  latched window exceeded the saturation limit
interface freq_meter_if;
  logic        sig_in;
  logic        hold;
  logic [31:0] data;
  logic        valid;
  logic        overflow;

  modport master (
    input  sig_in,
    input  hold,
    output data,
    output valid,
    output overflow
  );

  modport slave (
    output sig_in,
    output hold,
    input  data,
    input  valid,
    input  overflow
  );
endinterface

// File: rtl/freq_meter.sv
// freq_meter
//   Gated frequency meter. Counts rising edges of an asynchronous input over a
//   window of GATE_CYCLES clocks, saturating at MAX_COUNT so an 8-digit display
//   never wraps, and presents each completed count on bus.data.
//   Ports
//     clk   system clock
//     rst   asynchronous, active-high reset
//     bus   freq_meter_if.master (sig_in, hold in; data, valid, overflow out)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_COUNT | gate window open, synchronized rising edges are counted
//   S_LATCH | window closed; result latched to outputs unless hold=1
//   S_CLEAR | valid pulse high; counters cleared for the next window
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter int unsigned MAX_COUNT   = 99_999_999,
  parameter int unsigned CNT_W       = 27
) (
  input  logic         clk,
  input  logic         rst,
  freq_meter_if.master bus
);

  localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);

  typedef enum logic [1:0] {
    S_COUNT = 2'd0,
    S_LATCH = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t            state;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              ovf_flag;

  // s1/s2 form the synchronizer; s3 only delays s2 for edge detection
  logic s1, s2, s3;
  logic edge_det;

  logic [CNT_W-1:0] data_q;
  logic             valid_q;
  logic             ovf_q;

  assign edge_det = s2 & ~s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      state    <= S_COUNT;
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_flag <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      s1 <= bus.sig_in;
      s2 <= s1;
      s3 <= s2;

      case (state)
        S_COUNT: begin
          // saturate rather than wrap; the flag remembers we clipped
          if (edge_det) begin
            if (edge_cnt == CNT_MAX) begin
              ovf_flag <= 1'b1;
            end else begin
              edge_cnt <= edge_cnt + CNT_ONE;
            end
          end
          if (gate_cnt == GATE_LAST) begin
            state <= S_LATCH;
          end else begin
            gate_cnt <= gate_cnt + GATE_ONE;
          end
        end

        S_LATCH: begin
          // hold only matters here; the window itself always runs
          if (!bus.hold) begin
            data_q  <= edge_cnt;
            ovf_q   <= ovf_flag;
            valid_q <= 1'b1;
          end
          state <= S_CLEAR;
        end

        S_CLEAR: begin
          valid_q  <= 1'b0;
          edge_cnt <= '0;
          ovf_flag <= 1'b0;
          gate_cnt <= '0;
          state    <= S_COUNT;
        end

        default: begin
          valid_q  <= 1'b0;
          edge_cnt <= '0;
          ovf_flag <= 1'b0;
          gate_cnt <= '0;
          state    <= S_COUNT;
        end
      endcase
    end
  end

  assign bus.data     = 32'(data_q);
  assign bus.valid    = valid_q;
  assign bus.overflow = ovf_q;

endmodule
